// File: rtl/mem_req_ctrl.sv
// Request sequencer in front of a single-port synchronous memory.
// Define MEMCTL_CLEAR_EN to zero-fill the memory after every reset.
module mem_req_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
`ifdef MEMCTL_CLEAR_EN
  localparam logic [2:0] S_CLEAR = 3'd5;
  localparam logic [2:0] S_RST   = S_CLEAR;
`else
  localparam logic [2:0] S_RST   = S_IDLE;
`endif

  logic [2:0]            state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          mem_addr_d  = req_addr;
          if (req_wr) begin
            state_d     = S_WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d  = S_READ;
            mem_rd_d = 1'b1;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_WRITE: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      S_READ: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        state_d     = S_RESP;
        rsp_rdata_d = mem_rdata;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
`ifdef MEMCTL_CLEAR_EN
      // mem_wr_q low marks the first sweep cycle after reset
      S_CLEAR: begin
        mem_wdata_d = '0;
        if (!mem_wr_q) begin
          mem_wr_d   = 1'b1;
          mem_addr_d = '0;
        end else if (&mem_addr_q) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
        end else begin
          mem_wr_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        end
      end
`endif
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_) begin
    if (rst) begin
      state_q     <= S_RST;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a behavioural memory.
// Reference: array of expected contents plus a queue of expected reads.
module tb_mem_req_ctrl;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;
`ifdef MEMCTL_CLEAR_EN
  localparam int READY_LAT = 33;
`else
  localparam int READY_LAT = 1;
`endif

  logic          clk_ = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] mem_rdata;
  logic          req_ready, rsp_valid, mem_rd, mem_wr;
  logic [DW-1:0] rsp_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk_ = ~clk_;

  mem_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_(clk_), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // behavioural single-port memory driven by the DUT strobes
  logic [DW-1:0] tmem [DEPTH];
  logic          tmem_init = 1'b0;
  always @(posedge clk_) begin
    if (!tmem_init) begin
      for (int i = 0; i < DEPTH; i++) tmem[i] <= '0;
      mem_rdata <= '0;
      tmem_init <= 1'b1;
    end else begin
      if (mem_wr) tmem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= tmem[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(bit ok, string name,
                              logic [31:0] act, logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_init = 1'b0;
  logic [DW-1:0] rsp_q [$];
  int            acc_q [$];
  int            cyc = 0;
  int            pend_kind = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_data = '0;
  bit            in_clear = 1'b0;
  bit            prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_d;
  int            rdy_mode = 0;

  always @(posedge clk_ or negedge clk_) begin
    if (clk_) begin
      if (!ref_init) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_init = 1'b1;
      end
      if (rst) begin
        rsp_q.delete();
        acc_q.delete();
        pend_kind = 0;
`ifdef MEMCTL_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        in_clear = 1'b1;
`endif
      end else begin
        if (rsp_valid && rsp_ready) begin
          if (rsp_q.size() == 0) begin
            chk(1'b0 == rsp_valid, "rsp_extra", rsp_rdata, 0);
          end else begin
            exp_d = rsp_q.pop_front();
            void'(acc_q.pop_front());
            chk(rsp_rdata == exp_d, "rsp_data", rsp_rdata, exp_d);
          end
        end
        if (req_valid && req_ready) begin
          pend_addr = req_addr;
          if (req_wr) begin
            ref_mem[req_addr] = req_wdata;
            pend_kind = 1;
            pend_data = req_wdata;
          end else begin
            pend_kind = 2;
            rsp_q.push_back(ref_mem[req_addr]);
            acc_q.push_back(cyc);
          end
        end
      end
      cyc++;
    end else begin
      chk(!(mem_rd && mem_wr), "strobe_excl", {mem_rd, mem_wr}, 0);
      if (pend_kind == 1) begin
        chk(mem_wr && !mem_rd, "wr_strobe", {mem_rd, mem_wr}, 1);
        chk(mem_addr == pend_addr, "wr_addr", mem_addr, pend_addr);
        chk(mem_wdata == pend_data, "wr_data", mem_wdata, pend_data);
      end else if (pend_kind == 2) begin
        chk(mem_rd && !mem_wr, "rd_strobe", {mem_rd, mem_wr}, 2);
        chk(mem_addr == pend_addr, "rd_addr", mem_addr, pend_addr);
      end else begin
        chk(!mem_rd && !(mem_wr && !in_clear), "stray_strobe",
            {mem_rd, mem_wr}, 0);
      end
      pend_kind = 0;
      if (req_ready) in_clear = 1'b0;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk(!rsp_valid, "rsp_unexpected", rsp_valid, 0);
        end else if (!prev_valid) begin
          chk(cyc - acc_q[0] == 3, "rsp_latency", cyc - acc_q[0], 3);
        end
        if (prev_valid)
          chk(rsp_rdata == prev_data, "rsp_hold", rsp_rdata, prev_data);
        chk(!req_ready, "ready_busy", req_ready, 0);
      end
      prev_valid = rsp_valid;
      prev_data  = rsp_rdata;
    end
  end

  initial begin
    forever begin
      @(negedge clk_);
      if (rdy_mode == 0) rsp_ready = ($urandom % 3) != 0;
    end
  end

  task automatic send(input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 300) begin
      @(negedge clk_);
      n++;
    end
    chk(req_ready == 1'b1, "req_wait", n, 300);
    @(negedge clk_);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk_);
      n++;
    end while (!req_ready && n < 100);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk_);
      n++;
    end
    chk(n < 500, "drain", n, 500);
  endtask

  int n;
  int c0;

  initial begin
    repeat (3) @(negedge clk_);
    chk(req_ready == 1'b0, "rst_req_ready", req_ready, 0);
    chk(rsp_valid == 1'b0, "rst_rsp_valid", rsp_valid, 0);
    chk(rsp_rdata == '0, "rst_rsp_rdata", rsp_rdata, 0);
    chk(mem_rd == 1'b0, "rst_mem_rd", mem_rd, 0);
    chk(mem_wr == 1'b0, "rst_mem_wr", mem_wr, 0);
    chk(mem_addr == '0, "rst_mem_addr", mem_addr, 0);
    chk(mem_wdata == '0, "rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    wait_ready(n);
    chk(n == READY_LAT, "ready_after_reset", n, READY_LAT);

    send(1'b1, 5'h03, 8'hA5);
    send(1'b0, 5'h03, 8'h00);
    req_valid = 1'b0;
    drain();

    send(1'b1, 5'h1F, 8'h3C);
    rdy_mode  = 1;
    rsp_ready = 1'b0;
    send(1'b0, 5'h1F, 8'h00);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk_);
      n++;
    end
    repeat (5) begin
      chk(rsp_valid == 1'b1, "bp_valid", rsp_valid, 1);
      chk(rsp_rdata == 8'h3C, "bp_data", rsp_rdata, 8'h3C);
      chk(req_ready == 1'b0, "bp_ready", req_ready, 0);
      @(negedge clk_);
    end
    rsp_ready = 1'b1;
    @(negedge clk_);
    chk(rsp_valid == 1'b0, "bp_release_valid", rsp_valid, 0);
    chk(req_ready == 1'b1, "bp_release_ready", req_ready, 1);
    rdy_mode = 0;

    c0 = cyc;
    for (int i = 0; i < DEPTH; i++) send(1'b1, AW'(i), DW'(i));
    chk(cyc - c0 == 63, "wr_throughput", cyc - c0, 63);
    for (int i = 0; i < DEPTH; i++) send(1'b0, AW'(i), 8'h00);
    req_valid = 1'b0;
    drain();

    send(1'b1, 5'h09, 8'h5A);
    send(1'b0, 5'h09, 8'h00);
    req_valid = 1'b0;
    @(negedge clk_);
    rst = 1'b1;
    @(negedge clk_);
    chk(rsp_valid == 1'b0, "midrst_valid", rsp_valid, 0);
    chk(req_ready == 1'b0, "midrst_ready", req_ready, 0);
    chk(mem_rd == 1'b0, "midrst_rd", mem_rd, 0);
    rst = 1'b0;
    wait_ready(n);
    chk(n == READY_LAT, "midrst_ready_lat", n, READY_LAT);
    send(1'b0, 5'h09, 8'h00);
    req_valid = 1'b0;
    drain();

    repeat (80) begin
      send(1'($urandom % 2), AW'($urandom % 8), DW'($urandom));
      if ($urandom % 4 == 0) begin
        req_valid = 1'b0;
        @(negedge clk_);
      end
    end
    req_valid = 1'b0;
    drain();

`ifdef MEMCTL_CLEAR_EN
    send(1'b1, 5'h07, 8'hFF);
    req_valid = 1'b0;
    drain();
    rst = 1'b1;
    repeat (2) @(negedge clk_);
    rst = 1'b0;
    wait_ready(n);
    chk(n == READY_LAT, "clear_ready_lat", n, READY_LAT);
    send(1'b0, 5'h07, 8'h00);
    req_valid = 1'b0;
    drain();
    rst = 1'b1;
    @(negedge clk_);
    rst = 1'b0;
    n = 0;
    while (!(mem_wr && mem_addr == 5'd10) && n < 100) begin
      @(negedge clk_);
      n++;
    end
    chk(mem_addr == 5'd10, "clear_reach_10", mem_addr, 10);
    rst = 1'b1;
    @(negedge clk_);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk_);
      n++;
    end while (!mem_wr && n < 5);
    chk(mem_wr && mem_addr == '0, "clear_restart", mem_addr, 0);
    wait_ready(n);
    chk(req_ready == 1'b1, "clear_done", req_ready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
